// File: rtl/ife_pkg.sv
// Shared types and constants for the IFE commit sequencer.
package ife_pkg;

    localparam logic [1:0] FaultCodeNone      = 2'b00;
    localparam logic [1:0] FaultCodeMalformed = 2'b01;
    localparam logic [1:0] FaultCodeOrder     = 2'b10;
    localparam logic [1:0] FaultCodeTimeout   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StReplayReq,
        StReplayWait,
        StRetire,
        StFault
    } ife_seq_state_e;

    typedef enum logic [1:0] {
        FaultNone      = FaultCodeNone,
        FaultMalformed = FaultCodeMalformed,
        FaultOrder     = FaultCodeOrder,
        FaultTimeout   = FaultCodeTimeout
    } ife_fault_e;

endpackage

// File: rtl/ife_sat_counter.sv
// Saturating up-counter used for the retirement statistics.
module ife_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ife_commit_sequencer.sv
// In-order retirement sequencer: retires agreed blocks, replays mismatched ones serially,
// and latches a sticky fault on any protocol violation.
module ife_commit_sequencer
    import ife_pkg::*;
#(
    parameter int unsigned BLOCK_ID_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BLOCK_ID_WIDTH-1:0] in_block_id,
    input  logic                      in_commit_ok,
    input  logic                      in_commit_fail,
    output logic                      replay_valid,
    input  logic                      replay_ready,
    output logic [BLOCK_ID_WIDTH-1:0] replay_block_id,
    input  logic                      replay_done,
    input  logic [BLOCK_ID_WIDTH-1:0] replay_done_id,
    output logic                      retire_valid,
    input  logic                      retire_ready,
    output logic [BLOCK_ID_WIDTH-1:0] retire_block_id,
    output logic                      retire_replayed,
    output logic                      fault,
    output logic [1:0]                fault_code,
    output logic [CNT_WIDTH-1:0]      ok_count,
    output logic [CNT_WIDTH-1:0]      replay_count,
    output logic                      busy
);

    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);

    ife_seq_state_e            state_q, state_d;
    ife_fault_e                fault_q, fault_d;
    logic [BLOCK_ID_WIDTH-1:0] block_id_q, block_id_d;
    logic [BLOCK_ID_WIDTH-1:0] expected_id_q, expected_id_d;
    logic                      replayed_q, replayed_d;
    logic [TimerWidth-1:0]     timer_q, timer_d;
    logic                      retire_hs;

    assign retire_hs = (state_q == StRetire) && retire_ready;

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        block_id_d    = block_id_q;
        expected_id_d = expected_id_q;
        replayed_d    = replayed_q;
        timer_d       = timer_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    block_id_d = in_block_id;
                    replayed_d = 1'b0;
                    if (in_commit_ok == in_commit_fail) begin
                        state_d = StFault;
                        fault_d = FaultMalformed;
                    end else if (in_block_id != expected_id_q) begin
                        state_d = StFault;
                        fault_d = FaultOrder;
                    end else if (in_commit_ok) begin
                        state_d = StRetire;
                    end else begin
                        state_d = StReplayReq;
                    end
                end
            end
            StReplayReq: begin
                if (replay_ready) begin
                    state_d = StReplayWait;
                    timer_d = '0;
                end
            end
            StReplayWait: begin
                timer_d = timer_q + TimerWidth'(1);
                // A done pulse takes priority over a timeout landing in the same cycle.
                if (replay_done) begin
                    if (replay_done_id == block_id_q) begin
                        state_d    = StRetire;
                        replayed_d = 1'b1;
                    end else begin
                        state_d = StFault;
                        fault_d = FaultOrder;
                    end
                end else if (timer_d == TimerWidth'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StFault;
                    fault_d = FaultTimeout;
                end
            end
            StRetire: begin
                if (retire_ready) begin
                    expected_id_d = expected_id_q + BLOCK_ID_WIDTH'(1);
                    state_d       = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            fault_q       <= FaultNone;
            block_id_q    <= '0;
            expected_id_q <= '0;
            replayed_q    <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            block_id_q    <= block_id_d;
            expected_id_q <= expected_id_d;
            replayed_q    <= replayed_d;
            timer_q       <= timer_d;
        end
    end

    assign in_ready        = (state_q == StIdle);
    assign replay_valid    = (state_q == StReplayReq);
    assign retire_valid    = (state_q == StRetire);
    assign fault           = (state_q == StFault);
    assign busy            = (state_q != StIdle);
    assign fault_code      = fault_q;
    assign replay_block_id = block_id_q;
    assign retire_block_id = block_id_q;
    assign retire_replayed = replayed_q;

    ife_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_ok_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (retire_hs && !replayed_q),
        .count(ok_count)
    );

    ife_sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_replay_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (retire_hs && replayed_q),
        .count(replay_count)
    );

endmodule

// File: tb/tb_ife_commit_sequencer.sv
// Directed, table-driven bench: a wide instance for the main paths and a narrow one for
// ID wrap and counter saturation.
module tb_ife_commit_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 8-bit IDs, 16-cycle timeout, 16-bit counters.
    logic        a_in_valid, a_in_ready, a_ok, a_fail;
    logic [7:0]  a_in_block_id, a_replay_block_id, a_replay_done_id, a_retire_block_id;
    logic        a_replay_valid, a_replay_ready, a_replay_done;
    logic        a_retire_valid, a_retire_ready, a_retire_replayed;
    logic        a_fault, a_busy;
    logic [1:0]  a_fault_code;
    logic [15:0] a_ok_count, a_replay_count;

    // Instance B: 2-bit IDs, 2-bit counters.
    logic        b_in_valid, b_in_ready, b_ok, b_fail;
    logic [1:0]  b_in_block_id, b_replay_block_id, b_retire_block_id;
    logic        b_replay_valid, b_retire_valid, b_retire_replayed;
    logic        b_fault, b_busy;
    logic [1:0]  b_fault_code, b_ok_count, b_replay_count;
    logic        b_retire_ready = 1'b1;
    logic        b_replay_ready = 1'b0;
    logic        b_replay_done = 1'b0;
    logic [1:0]  b_replay_done_id = 2'd0;

    ife_commit_sequencer #(
        .BLOCK_ID_WIDTH(8),
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH     (16)
    ) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (a_in_valid),
        .in_ready       (a_in_ready),
        .in_block_id    (a_in_block_id),
        .in_commit_ok   (a_ok),
        .in_commit_fail (a_fail),
        .replay_valid   (a_replay_valid),
        .replay_ready   (a_replay_ready),
        .replay_block_id(a_replay_block_id),
        .replay_done    (a_replay_done),
        .replay_done_id (a_replay_done_id),
        .retire_valid   (a_retire_valid),
        .retire_ready   (a_retire_ready),
        .retire_block_id(a_retire_block_id),
        .retire_replayed(a_retire_replayed),
        .fault          (a_fault),
        .fault_code     (a_fault_code),
        .ok_count       (a_ok_count),
        .replay_count   (a_replay_count),
        .busy           (a_busy)
    );

    ife_commit_sequencer #(
        .BLOCK_ID_WIDTH(2),
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH     (2)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (b_in_valid),
        .in_ready       (b_in_ready),
        .in_block_id    (b_in_block_id),
        .in_commit_ok   (b_ok),
        .in_commit_fail (b_fail),
        .replay_valid   (b_replay_valid),
        .replay_ready   (b_replay_ready),
        .replay_block_id(b_replay_block_id),
        .replay_done    (b_replay_done),
        .replay_done_id (b_replay_done_id),
        .retire_valid   (b_retire_valid),
        .retire_ready   (b_retire_ready),
        .retire_block_id(b_retire_block_id),
        .retire_replayed(b_retire_replayed),
        .fault          (b_fault),
        .fault_code     (b_fault_code),
        .ok_count       (b_ok_count),
        .replay_count   (b_replay_count),
        .busy           (b_busy)
    );

    typedef struct {
        logic [7:0]  id;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl_a[10];
    vec_t tbl_b[8];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_in_ready"}, a_in_ready, 1);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_replay_valid"}, a_replay_valid, 0);
        check({tag, "_retire_valid"}, a_retire_valid, 0);
        check({tag, "_retire_replayed"}, a_retire_replayed, 0);
        check({tag, "_fault"}, a_fault, 0);
        check({tag, "_fault_code"}, a_fault_code, 0);
        check({tag, "_ok_count"}, a_ok_count, 0);
        check({tag, "_replay_count"}, a_replay_count, 0);
        check({tag, "_replay_id"}, a_replay_block_id, 0);
        check({tag, "_retire_id"}, a_retire_block_id, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Present one verdict to A for one cycle; returns one cycle after acceptance.
    task automatic send_a(input logic [7:0] id, input logic ok, input logic fail);
        a_in_valid    = 1'b1;
        a_in_block_id = id;
        a_ok          = ok;
        a_fail        = fail;
        step();
        a_in_valid = 1'b0;
        a_ok       = 1'b0;
        a_fail     = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] id);
        b_in_valid    = 1'b1;
        b_in_block_id = id;
        b_ok          = 1'b1;
        b_fail        = 1'b0;
        step();
        b_in_valid = 1'b0;
        b_ok       = 1'b0;
    endtask

    task automatic pulse_done_a(input logic [7:0] id);
        a_replay_done    = 1'b1;
        a_replay_done_id = id;
        step();
        a_replay_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 10; i++) begin
            tbl_a[i].id      = 8'(i);
            tbl_a[i].exp_cnt = 16'(i + 1);
        end
        tbl_b = '{'{8'd0, 16'd1}, '{8'd1, 16'd2}, '{8'd2, 16'd3}, '{8'd3, 16'd3},
                  '{8'd0, 16'd3}, '{8'd1, 16'd3}, '{8'd2, 16'd3}, '{8'd3, 16'd3}};

        a_in_valid = 1'b0; a_in_block_id = '0; a_ok = 1'b0; a_fail = 1'b0;
        a_replay_ready = 1'b0; a_replay_done = 1'b0; a_replay_done_id = '0;
        a_retire_ready = 1'b1;
        b_in_valid = 1'b0; b_in_block_id = '0; b_ok = 1'b0; b_fail = 1'b0;

        #2;
        check_reset_a("reset");
        step();
        rst_n = 1'b1;

        // Ten ok verdicts back to back, one block per two cycles.
        for (int i = 0; i < 10; i++) begin
            check("ok_in_ready", a_in_ready, 1);
            send_a(tbl_a[i].id, 1'b1, 1'b0);
            check("ok_retire_valid", a_retire_valid, 1);
            check("ok_retire_id", a_retire_block_id, tbl_a[i].id);
            check("ok_retire_replayed", a_retire_replayed, 0);
            step();
            check("ok_count", a_ok_count, tbl_a[i].exp_cnt);
        end
        check("ok_replay_count", a_replay_count, 0);

        // Fail path with delayed replay_ready, ignored early dones, retire back-pressure.
        do_reset();
        send_a(8'd0, 1'b0, 1'b1);
        check("rp_replay_valid", a_replay_valid, 1);
        check("rp_replay_id", a_replay_block_id, 0);
        check("rp_in_ready", a_in_ready, 0);
        pulse_done_a(8'd0);
        check("rp_done_in_req_ignored", a_replay_valid, 1);
        step();
        check("rp_held", a_replay_valid, 1);
        a_replay_ready   = 1'b1;
        a_replay_done    = 1'b1;
        a_replay_done_id = 8'd0;
        step();
        a_replay_ready = 1'b0;
        a_replay_done  = 1'b0;
        check("rp_wait_no_replay_valid", a_replay_valid, 0);
        check("rp_wait_no_retire", a_retire_valid, 0);
        check("rp_wait_busy", a_busy, 1);
        for (int i = 0; i < 4; i++) step();
        check("rp_wait_still", a_retire_valid, 0);
        a_retire_ready = 1'b0;
        pulse_done_a(8'd0);
        check("rp_retire_valid", a_retire_valid, 1);
        check("rp_retire_replayed", a_retire_replayed, 1);
        check("rp_retire_id", a_retire_block_id, 0);
        step();
        check("rp_retire_held", a_retire_valid, 1);
        check("rp_retire_held_replayed", a_retire_replayed, 1);
        a_retire_ready = 1'b1;
        step();
        check("rp_back_idle", a_in_ready, 1);
        check("rp_replay_count", a_replay_count, 1);
        check("rp_ok_count", a_ok_count, 0);

        // Timeout: handshake at M, fault visible at M+16 and sticky afterwards.
        send_a(8'd1, 1'b0, 1'b1);
        a_replay_ready = 1'b1;
        step();
        a_replay_ready = 1'b0;
        for (int i = 1; i < 15; i++) step();
        check("to_no_fault_m15", a_fault, 0);
        step();
        check("to_fault", a_fault, 1);
        check("to_fault_code", a_fault_code, 3);
        check("to_in_ready", a_in_ready, 0);
        a_in_valid = 1'b1; a_in_block_id = 8'd2; a_ok = 1'b1;
        step(); step();
        a_in_valid = 1'b0; a_ok = 1'b0;
        check("to_sticky_in_ready", a_in_ready, 0);
        check("to_sticky_retire", a_retire_valid, 0);
        check("to_sticky_code", a_fault_code, 3);

        // Done and timeout in the same cycle: done wins.
        do_reset();
        send_a(8'd0, 1'b0, 1'b1);
        a_replay_ready = 1'b1;
        step();
        a_replay_ready = 1'b0;
        for (int i = 1; i < 15; i++) step();
        pulse_done_a(8'd0);
        check("tie_no_fault", a_fault, 0);
        check("tie_retire", a_retire_valid, 1);

        // Done with the wrong ID while waiting.
        do_reset();
        send_a(8'd0, 1'b0, 1'b1);
        a_replay_ready = 1'b1;
        step();
        a_replay_ready = 1'b0;
        step();
        pulse_done_a(8'd7);
        check("badid_fault", a_fault, 1);
        check("badid_code", a_fault_code, 2);

        // Out-of-order ID.
        do_reset();
        send_a(8'd5, 1'b1, 1'b0);
        check("order_fault", a_fault, 1);
        check("order_code", a_fault_code, 2);
        check("order_no_retire", a_retire_valid, 0);

        // Malformed verdicts: both set, and neither set.
        do_reset();
        send_a(8'd0, 1'b1, 1'b1);
        check("mal_both_code", a_fault_code, 1);
        do_reset();
        send_a(8'd0, 1'b0, 1'b0);
        check("mal_none_code", a_fault_code, 1);
        check("mal_none_fault", a_fault, 1);

        // Narrow instance: ID wrap and counter saturation.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check("wrap_in_ready", b_in_ready, 1);
            send_b(tbl_b[i].id[1:0]);
            check("wrap_retire_valid", b_retire_valid, 1);
            check("wrap_retire_id", b_retire_block_id, tbl_b[i].id);
            step();
            check("wrap_ok_count", b_ok_count, tbl_b[i].exp_cnt);
        end
        check("wrap_no_fault", b_fault, 0);
        send_b(2'd0);
        check("wrap_expected_back_to_0", b_retire_valid, 1);
        step();
        check("wrap_sat_hold", b_ok_count, 3);

        // Asynchronous reset while waiting on a replay.
        do_reset();
        send_a(8'd0, 1'b0, 1'b1);
        a_replay_ready = 1'b1;
        step();
        a_replay_ready = 1'b0;
        step();
        check("midrst_busy_before", a_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("midrst");
        step();
        rst_n = 1'b1;
        pulse_done_a(8'd0);
        check("midrst_done_ignored", a_retire_valid, 0);
        send_a(8'd0, 1'b1, 1'b0);
        check("midrst_retire", a_retire_valid, 1);
        check("midrst_retire_id", a_retire_block_id, 0);
        check("midrst_retire_replayed", a_retire_replayed, 0);
        step();
        check("midrst_ok_count", a_ok_count, 1);
        check("midrst_replay_count", a_replay_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ife_commit_sequencer.md
# ife_commit_sequencer

In-order retirement sequencer directly downstream of the IFE commit unit. It consumes one commit verdict per block. Agreed blocks retire immediately. Mismatched blocks get a serial re-execution request, and the block retires only once that replay completes. The block enforces strict block-ID order, bounds replay latency with a timeout, and raises a sticky fault on any protocol violation.

## Interface
Parameters:
- BLOCK_ID_WIDTH, 8: width of block identifiers.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in REPLAY_WAIT; must be ≥ 2.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a commit verdict is present.
- in_ready  out  1  the sequencer accepts a verdict this cycle.
- in_block_id  in  BLOCK_ID_WIDTH  ID of the judged block.
- in_commit_ok  in  1  verdict: results agree.
- in_commit_fail  in  1  verdict: mismatch, serial re-execution required.
- replay_valid  out  1  serial re-execution request.
- replay_ready  in  1  serial core accepts the request.
- replay_block_id  out  BLOCK_ID_WIDTH  block to re-execute.
- replay_done  in  1  serial re-execution finished (single-cycle pulse).
- replay_done_id  in  BLOCK_ID_WIDTH  ID of the finished block.
- retire_valid  out  1  block is ready to retire.
- retire_ready  in  1  the architectural-state consumer accepts the retirement.
- retire_block_id  out  BLOCK_ID_WIDTH  retiring block.
- retire_replayed  out  1  the retiring block went through serial replay.
- fault  out  1  sticky error flag; cleared only by reset.
- fault_code  out  2  01 = malformed verdict, 10 = ID/order mismatch, 11 = replay timeout.
- ok_count  out  CNT_WIDTH  saturating count of non-replayed retirements.
- replay_count  out  CNT_WIDTH  saturating count of replayed retirements.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, REPLAY_REQ, REPLAY_WAIT, RETIRE, FAULT.
- expected_id register: reset value 0. It increments by 1, modulo 2^BLOCK_ID_WIDTH, on each retire handshake. Wrap from all-ones to 0 is legal.
- IDLE: in_ready = 1. A verdict is accepted when in_valid && in_ready. The accepted block_id is captured, then the verdict is checked in this priority order:
  - in_commit_ok == in_commit_fail (both 0 or both 1): go to FAULT with code 01.
  - in_block_id != expected_id: go to FAULT with code 10.
  - in_commit_ok: go to RETIRE with replayed = 0.
  - in_commit_fail: go to REPLAY_REQ.
- REPLAY_REQ: replay_valid = 1 and is held stable until replay_valid && replay_ready. On that handshake, go to REPLAY_WAIT and clear the timer to 0.
- REPLAY_WAIT: the timer increments each cycle.
  - replay_done with matching ID: go to RETIRE with replayed = 1.
  - replay_done with a different ID: go to FAULT with code 10.
  - Timer reaches TIMEOUT_CYCLES-1 with no done: go to FAULT with code 11.
- RETIRE: retire_valid = 1, with retire_block_id and retire_replayed held stable. On the handshake, increment ok_count or replay_count (as selected by replayed) and expected_id, then go to IDLE.
- FAULT: absorbing state. in_ready, replay_valid and retire_valid are all 0. fault = 1 and fault_code is frozen.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values, asserted asynchronously:
  - State = IDLE; in_ready = 1.
  - replay_valid = retire_valid = retire_replayed = 0.
  - fault = 0, fault_code = 00.
  - Both counters = 0, expected_id = 0, timer = 0, busy = 0.
  - All ID outputs = 0.
- All outputs are registered or decoded directly from the state register; there is no combinational path from any input to any output.
- OK path: verdict accepted at cycle N; retire_valid is high at N+1; with retire_ready = 1, in_ready is high again at N+2. Peak throughput is one block per 2 cycles.
- Fail path: verdict accepted at N; replay_valid is high at N+1; after the request handshake at cycle M, the state is REPLAY_WAIT at M+1.
  - A replay_done arriving in REPLAY_REQ, or in the cycle of the request handshake, is ignored.
  - A replay_done arriving while the state is IDLE or RETIRE is ignored.
- Timeout and a matching done in the same cycle: done wins.
- Back-pressure: retire_ready or replay_ready may stay low indefinitely. No timeout applies in REPLAY_REQ or RETIRE.
- Reset asserted mid-replay or mid-retire: the request is dropped immediately and the block is not retired.

## Structure
- ife_pkg holds:
  - the state enum ife_seq_state_e;
  - the fault-code enum ife_fault_e (NONE, MALFORMED, ORDER, TIMEOUT);
  - fault-code localparams.
- One sub-module, ife_sat_counter (parameter WIDTH; ports clk, rst_n, inc, count), instantiated twice, once for each statistics counter.
- The timer is a local $clog2(TIMEOUT_CYCLES)-bit register.

## Test plan
- Ten ok verdicts for IDs 0..9 with retire_ready = 1 → ten retirements in order, retire_replayed = 0, ok_count = 10, spacing 2 cycles.
- Fail verdict for ID 0, replay_ready delayed 3 cycles, replay_done with ID 0 five cycles later → replay_block_id = 0, one retirement with retire_replayed = 1, replay_count = 1.
- Fail verdict with no replay_done and TIMEOUT_CYCLES = 16 → fault = 1 and fault_code = 11 exactly 16 cycles after the replay handshake; in_ready stays 0 afterwards.
- Verdict with ID 5 while expected_id = 0 → fault_code = 10. Verdict with both ok and fail = 1 → fault_code = 01.
- BLOCK_ID_WIDTH = 2, with eight ok verdicts for IDs 0,1,2,3,0,1,2,3 → no fault, and expected_id wraps to 0. CNT_WIDTH = 2 with five retirements → ok_count saturates at 3.
- rst_n asserted while in REPLAY_WAIT → all outputs are at reset values in the same cycle, and a fresh ok verdict for ID 0 then retires normally.
